// File: rtl/fetch_stage_if.sv
// Instruction memory bus between the fetch stage (master) and memory (slave).
// Handshake: while iREN=1 the master holds iaddr stable; the slave answers by
// raising ihit for one cycle with iload valid. Dropping iREN abandons the
// outstanding request.
interface fetch_stage_if #(
    parameter int WORD_W = 32
);
    logic              iREN;
    logic [WORD_W-1:0] iaddr;
    logic [WORD_W-1:0] iload;
    logic              ihit;

    modport master (
        output iREN,
        output iaddr,
        input  iload,
        input  ihit
    );

    modport slave (
        input  iREN,
        input  iaddr,
        output iload,
        output ihit
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: requests the instruction at pco, computes the next
// PC (pco+4 or a redirect target), and fills the IF/ID pipeline register.
// Handles stall, redirect with squash of an in-flight request, and halt.
// The FSM state is exported on dbg_state for observation.
module fetch_stage #(
    parameter int                WORD_W  = 32,
    parameter logic [WORD_W-1:0] PC_INIT = '0
) (
    input  logic              CLK,
    input  logic              nRST,
    // program counter interface
    input  logic [WORD_W-1:0] pco,
    output logic [WORD_W-1:0] pci,
    output logic              pc_wen,
    // instruction memory bus
    fetch_stage_if.master     imem,
    // hazard / control inputs
    input  logic              stall,
    input  logic              redirect_en,
    input  logic [WORD_W-1:0] redirect_pc,
    input  logic              halt,
    // IF/ID pipeline register
    output logic [WORD_W-1:0] ifid_instr,
    output logic [WORD_W-1:0] ifid_npc,
    output logic              ifid_valid,
    // FSM state for observation: 0 FETCH, 1 SQUASH, 2 HALTED
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        SQUASH = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t            state;
    logic [WORD_W-1:0] req_addr;   // address of the request being squashed
    logic [WORD_W-1:0] pc_plus4;   // wraps mod 2^WORD_W, no carry out

    assign pc_plus4  = pco + WORD_W'(4);
    assign dbg_state = state;

    // Memory request and PC update, combinational from state and inputs.
    always_comb begin
        imem.iREN  = 1'b0;
        imem.iaddr = pco;
        pci        = pc_plus4;
        pc_wen     = 1'b0;
        case (state)
            FETCH: begin
                imem.iREN = 1'b1;
                if (redirect_en) begin
                    pci    = redirect_pc;
                    pc_wen = 1'b1;
                end else if (halt && ifid_valid) begin
                    pc_wen = 1'b0;
                end else if (stall) begin
                    pc_wen = 1'b0;
                end else if (imem.ihit) begin
                    pc_wen = 1'b1;
                end
            end
            SQUASH: begin
                // keep the abandoned address stable until memory answers
                imem.iREN  = 1'b1;
                imem.iaddr = req_addr;
                if (redirect_en) begin
                    pci    = redirect_pc;
                    pc_wen = 1'b1;
                end
            end
            default: begin
                imem.iREN = 1'b0;
            end
        endcase
    end

    // FSM transitions, IF/ID register and squashed-request address.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state      <= FETCH;
            ifid_instr <= '0;
            ifid_npc   <= PC_INIT;
            ifid_valid <= 1'b0;
            req_addr   <= '0;
        end else begin
            case (state)
                FETCH: begin
                    if (redirect_en) begin
                        ifid_valid <= 1'b0;
                        if (!imem.ihit) begin
                            // response still outstanding: wait it out
                            state    <= SQUASH;
                            req_addr <= pco;
                        end
                    end else if (halt && ifid_valid) begin
                        ifid_valid <= 1'b0;
                        state      <= HALTED;
                    end else if (stall) begin
                        // IF/ID holds; a hit here is refetched later
                    end else if (imem.ihit) begin
                        ifid_instr <= imem.iload;
                        ifid_npc   <= pc_plus4;
                        ifid_valid <= 1'b1;
                    end else begin
                        ifid_valid <= 1'b0;
                    end
                end
                SQUASH: begin
                    ifid_valid <= 1'b0;
                    if (imem.ihit) begin
                        state <= FETCH;
                    end
                end
                default: begin
                    ifid_valid <= 1'b0;
                    state      <= HALTED;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed cycles with expected PC-side
// outputs, and a scoreboard of expected IF/ID entries.
module tb_fetch_stage;

    localparam int W = 32;
    localparam logic [1:0] ST_FETCH  = 2'd0;
    localparam logic [1:0] ST_SQUASH = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;

    logic          CLK;
    logic          nRST;
    logic [W-1:0]  pco;
    logic [W-1:0]  pci;
    logic          pc_wen;
    logic          stall;
    logic          redirect_en;
    logic [W-1:0]  redirect_pc;
    logic          halt;
    logic [W-1:0]  ifid_instr;
    logic [W-1:0]  ifid_npc;
    logic          ifid_valid;
    logic [1:0]    dbg_state;

    fetch_stage_if #(.WORD_W(W)) imem ();

    fetch_stage #(.WORD_W(W), .PC_INIT('0)) dut (
        .CLK         (CLK),
        .nRST        (nRST),
        .pco         (pco),
        .pci         (pci),
        .pc_wen      (pc_wen),
        .imem        (imem),
        .stall       (stall),
        .redirect_en (redirect_en),
        .redirect_pc (redirect_pc),
        .halt        (halt),
        .ifid_instr  (ifid_instr),
        .ifid_npc    (ifid_npc),
        .ifid_valid  (ifid_valid),
        .dbg_state   (dbg_state)
    );

    // clock / reset
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // scoreboard: {instr, npc} expected to appear in IF/ID
    logic [2*W-1:0] exp_q[$];
    logic [2*W-1:0] last_ent = '0;

    task automatic check_eq(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [W-1:0] instr, input logic [W-1:0] npc);
        exp_q.push_back({instr, npc});
    endtask

    // One cycle: drive inputs after the falling edge, check the combinational
    // outputs before the rising edge, then check IF/ID and state after it.
    task automatic cyc(
        input logic [W-1:0] pco_v, input logic ihit_v, input logic [W-1:0] iload_v,
        input logic stall_v, input logic red_v, input logic [W-1:0] rpc_v, input logic halt_v,
        input logic e_wen, input logic [W-1:0] e_pci, input logic e_iren,
        input logic [W-1:0] e_iaddr, input logic e_v, input logic [1:0] e_st
    );
        logic [2*W-1:0] ent;
        @(negedge CLK);
        pco         = pco_v;
        imem.ihit   = ihit_v;
        imem.iload  = iload_v;
        stall       = stall_v;
        redirect_en = red_v;
        redirect_pc = rpc_v;
        halt        = halt_v;
        #2;
        check_eq("pc_wen", {31'd0, pc_wen}, {31'd0, e_wen});
        check_eq("pci", pci, e_pci);
        check_eq("iREN", {31'd0, imem.iREN}, {31'd0, e_iren});
        if (e_iren) check_eq("iaddr", imem.iaddr, e_iaddr);
        @(posedge CLK);
        #1;
        check_eq("ifid_valid", {31'd0, ifid_valid}, {31'd0, e_v});
        check_eq("state", {30'd0, dbg_state}, {30'd0, e_st});
        if (e_v) begin
            if (exp_q.size() > 0) ent = exp_q.pop_front();
            else ent = last_ent;
            last_ent = ent;
            check_eq("ifid_instr", ifid_instr, ent[2*W-1:W]);
            check_eq("ifid_npc", ifid_npc, ent[W-1:0]);
        end
    endtask

    task automatic check_reset_values();
        check_eq("rst_valid", {31'd0, ifid_valid}, 32'd0);
        check_eq("rst_instr", ifid_instr, 32'd0);
        check_eq("rst_npc", ifid_npc, 32'd0);
        check_eq("rst_state", {30'd0, dbg_state}, {30'd0, ST_FETCH});
    endtask

    logic [W-1:0] rnd;

    initial begin
        nRST = 1'b0;
        pco = '0; imem.ihit = 1'b0; imem.iload = '0;
        stall = 1'b0; redirect_en = 1'b0; redirect_pc = '0; halt = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        check_reset_values();
        @(negedge CLK);
        nRST = 1'b1;

        // straight-line fetch
        push_exp(32'h2001_0005, 32'h4);
        cyc(32'h0, 1, 32'h2001_0005, 0, 0, 0, 0, 1, 32'h4, 1, 32'h0, 1, ST_FETCH);
        rnd = W'($urandom_range(0, 32'h7fff_ffff));
        push_exp(rnd, 32'h8);
        cyc(32'h4, 1, rnd, 0, 0, 0, 0, 1, 32'h8, 1, 32'h4, 1, ST_FETCH);

        // memory wait: three bubbles, then the hit
        for (int i = 0; i < 3; i++)
            cyc(32'h40, 0, 32'hdead_beef, 0, 0, 0, 0, 0, 32'h44, 1, 32'h40, 0, ST_FETCH);
        push_exp(32'h0aaa_0001, 32'h44);
        cyc(32'h40, 1, 32'h0aaa_0001, 0, 0, 0, 0, 1, 32'h44, 1, 32'h40, 1, ST_FETCH);

        // stall with a hit: IF/ID holds previous entry, PC not written
        cyc(32'h10, 1, 32'h1111_1111, 1, 0, 0, 0, 0, 32'h14, 1, 32'h10, 1, ST_FETCH);
        cyc(32'h10, 1, 32'h1111_1111, 1, 0, 0, 0, 0, 32'h14, 1, 32'h10, 1, ST_FETCH);
        push_exp(32'h0bbb_0002, 32'h14);
        cyc(32'h10, 1, 32'h0bbb_0002, 0, 0, 0, 0, 1, 32'h14, 1, 32'h10, 1, ST_FETCH);

        // redirect with request outstanding: squash, old address held
        cyc(32'h20, 0, 32'h0, 0, 1, 32'h100, 0, 1, 32'h100, 1, 32'h20, 0, ST_SQUASH);
        cyc(32'h100, 0, 32'h0, 0, 0, 0, 1, 0, 32'h104, 1, 32'h20, 0, ST_SQUASH);
        cyc(32'h100, 1, 32'h5555_5555, 0, 0, 0, 0, 0, 32'h104, 1, 32'h20, 0, ST_FETCH);
        push_exp(32'h0ccc_0003, 32'h104);
        cyc(32'h100, 1, 32'h0ccc_0003, 0, 0, 0, 0, 1, 32'h104, 1, 32'h100, 1, ST_FETCH);

        // redirect while squashing: last target wins
        cyc(32'h104, 0, 32'h0, 0, 1, 32'h200, 0, 1, 32'h200, 1, 32'h104, 0, ST_SQUASH);
        cyc(32'h200, 0, 32'h0, 0, 1, 32'h280, 0, 1, 32'h280, 1, 32'h104, 0, ST_SQUASH);
        cyc(32'h280, 1, 32'h6666_6666, 0, 0, 0, 0, 0, 32'h284, 1, 32'h104, 0, ST_FETCH);

        // redirect coinciding with a hit: data dropped, stay in FETCH
        cyc(32'h280, 1, 32'h7777_7777, 0, 1, 32'h300, 0, 1, 32'h300, 1, 32'h280, 0, ST_FETCH);

        // address wrap
        push_exp(32'h0ddd_0004, 32'h0);
        cyc(32'hffff_fffc, 1, 32'h0ddd_0004, 0, 0, 0, 0, 1, 32'h0, 1, 32'hffff_fffc, 1, ST_FETCH);

        // halt together with redirect: redirect wins
        cyc(32'h0, 1, 32'h8888_8888, 0, 1, 32'h300, 1, 1, 32'h300, 1, 32'h0, 0, ST_FETCH);
        // halt while IF/ID empty is not taken
        push_exp(32'h0eee_0005, 32'h304);
        cyc(32'h300, 1, 32'h0eee_0005, 0, 0, 0, 1, 1, 32'h304, 1, 32'h300, 1, ST_FETCH);
        // halt with valid IF/ID
        cyc(32'h304, 1, 32'h9999_9999, 0, 0, 0, 1, 0, 32'h308, 1, 32'h304, 0, ST_HALTED);
        for (int i = 0; i < 3; i++)
            cyc(32'h304, 1, 32'h9999_9999, 0, 1, 32'h400, 0, 0, 32'h308, 0, 32'h304, 0, ST_HALTED);

        // asynchronous reset mid-cycle recovers to FETCH
        @(negedge CLK);
        nRST = 1'b0;
        #1;
        check_reset_values();
        @(negedge CLK);
        nRST = 1'b1;
        push_exp(32'h0fff_0006, 32'h4);
        cyc(32'h0, 1, 32'h0fff_0006, 0, 0, 0, 0, 1, 32'h4, 1, 32'h0, 1, ST_FETCH);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries left expected 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
